// File: rtl/dcache_pkg.sv
// Shared types and field widths for the direct-mapped write-back data cache.
// Holds the controller state encoding and the word select / word-enable helpers.
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

    localparam int LINE_W = 256;
    localparam int WORD_W = 32;
    localparam int WORDS  = 8;
    localparam int OFF_W  = 3;
    localparam int BLK_W  = 5;

    // Extract word 'off' from a line; word w lives in bits [32w+31:32w].
    function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  off);
        return line[{off, 5'd0} +: WORD_W];
    endfunction

    // One-hot word enable for a store to word 'off'.
    function automatic logic [WORDS-1:0] word_onehot(input logic [OFF_W-1:0] off);
        return 8'b0000_0001 << off;
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the data cache: asynchronous read,
// one synchronous write port with per-word enables. Only valid/dirty reset.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int TAG_W = 22,
    parameter int IDX_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              we,
    input  logic [WORDS-1:0]  wr_word_en,
    input  logic [LINE_W-1:0] wr_line,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              wr_dirty
);

    logic [LINES-1:0]  valid_r;
    logic [LINES-1:0]  dirty_r;
    logic [TAG_W-1:0]  tag_r  [LINES];
    logic [LINE_W-1:0] data_r [LINES];

    // Line status bits: cleared on reset, any write marks the line valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {LINES{1'b0}};
            dirty_r <= {LINES{1'b0}};
        end else if (we) begin
            valid_r[idx] <= 1'b1;
            dirty_r[idx] <= wr_dirty;
        end
    end

    // Tag and data arrays carry no reset; a cleared valid bit hides stale contents.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_r[idx] <= wr_tag;
            for (int w = 0; w < WORDS; w++) begin
                if (wr_word_en[w]) begin
                    data_r[idx][w*WORD_W +: WORD_W] <= wr_line[w*WORD_W +: WORD_W];
                end
            end
        end
    end

    assign rd_valid = valid_r[idx];
    assign rd_dirty = dirty_r[idx];
    assign rd_tag   = tag_r[idx];
    assign rd_line  = data_r[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data cache controller: hit detection, word select/merge and the
// writeback/allocate FSM that talks to off-chip memory over a 256-bit req/ack port.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int TAG_W = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    input  logic              cpu_mem_read_i,
    input  logic              cpu_mem_write_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              mem_stall_o,
    output logic              mem_req_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int IW = $clog2(LINES);

    logic [IW-1:0]     idx_s;
    logic [TAG_W-1:0]  tag_s;
    logic [OFF_W-1:0]  off_s;
    logic              req_s;
    logic              hit_s;
    logic              line_valid_s;
    logic              line_dirty_s;
    logic [TAG_W-1:0]  line_tag_s;
    logic [LINE_W-1:0] line_data_s;

    logic              we_s;
    logic [WORDS-1:0]  word_en_s;
    logic [LINE_W-1:0] wr_line_s;
    logic              wr_dirty_s;
    logic [31:0]       cpu_rdata_s;
    logic              stall_s;

    state_t            state_r;
    logic              mem_req_r;
    logic              mem_write_r;
    logic [31:0]       mem_addr_r;
    logic [LINE_W-1:0] mem_wdata_r;

    logic              unused_s;

    assign idx_s    = cpu_addr_i[BLK_W+IW-1:BLK_W];
    assign tag_s    = cpu_addr_i[31:BLK_W+IW];
    assign off_s    = cpu_addr_i[4:2];
    assign req_s    = cpu_mem_read_i | cpu_mem_write_i;
    assign unused_s = ^cpu_addr_i[1:0];

    dcache_sram #(
        .LINES (LINES),
        .TAG_W (TAG_W),
        .IDX_W (IW)
    ) u_sram (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx_s),
        .rd_valid   (line_valid_s),
        .rd_dirty   (line_dirty_s),
        .rd_tag     (line_tag_s),
        .rd_line    (line_data_s),
        .we         (we_s),
        .wr_word_en (word_en_s),
        .wr_line    (wr_line_s),
        .wr_tag     (tag_s),
        .wr_dirty   (wr_dirty_s)
    );

    assign hit_s = line_valid_s & (line_tag_s == tag_s);

    // Hit path: load word select, store merge, refill write and the stall.
    always_comb begin
        cpu_rdata_s = 32'h0;
        we_s        = 1'b0;
        word_en_s   = {WORDS{1'b0}};
        wr_line_s   = {LINE_W{1'b0}};
        wr_dirty_s  = 1'b0;
        stall_s     = (state_r != ST_IDLE) | (req_s & ~hit_s);
        case (state_r)
            ST_IDLE: begin
                if (req_s & hit_s) begin
                    if (cpu_mem_write_i) begin
                        we_s       = 1'b1;
                        word_en_s  = word_onehot(off_s);
                        wr_line_s  = {WORDS{cpu_wdata_i}};
                        wr_dirty_s = 1'b1;
                    end else begin
                        cpu_rdata_s = word_sel(line_data_s, off_s);
                    end
                end else begin
                    we_s = 1'b0;
                end
            end
            ST_ALLOCATE: begin
                if (mem_ack_i & ~rst) begin
                    we_s       = 1'b1;
                    word_en_s  = {WORDS{1'b1}};
                    wr_line_s  = mem_rdata_i;
                    wr_dirty_s = 1'b0;
                end else begin
                    we_s = 1'b0;
                end
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // Miss FSM; memory-side outputs are loaded on each transition and held until ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mem_req_r   <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= 32'h0;
            mem_wdata_r <= {LINE_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s & ~hit_s & line_dirty_s) begin
                        state_r     <= ST_WRITEBACK;
                        mem_req_r   <= 1'b1;
                        mem_write_r <= 1'b1;
                        mem_addr_r  <= {line_tag_s, idx_s, 5'd0};
                        mem_wdata_r <= line_data_s;
                    end else if (req_s & ~hit_s) begin
                        state_r     <= ST_ALLOCATE;
                        mem_req_r   <= 1'b1;
                        mem_write_r <= 1'b0;
                        mem_addr_r  <= {tag_s, idx_s, 5'd0};
                        mem_wdata_r <= {LINE_W{1'b0}};
                    end else begin
                        state_r     <= ST_IDLE;
                        mem_req_r   <= 1'b0;
                        mem_write_r <= 1'b0;
                        mem_addr_r  <= 32'h0;
                        mem_wdata_r <= {LINE_W{1'b0}};
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_r     <= ST_ALLOCATE;
                        mem_req_r   <= 1'b1;
                        mem_write_r <= 1'b0;
                        mem_addr_r  <= {tag_s, idx_s, 5'd0};
                        mem_wdata_r <= {LINE_W{1'b0}};
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_ack_i) begin
                        state_r     <= ST_IDLE;
                        mem_req_r   <= 1'b0;
                        mem_write_r <= 1'b0;
                        mem_addr_r  <= 32'h0;
                        mem_wdata_r <= {LINE_W{1'b0}};
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    mem_req_r   <= 1'b0;
                    mem_write_r <= 1'b0;
                    mem_addr_r  <= 32'h0;
                    mem_wdata_r <= {LINE_W{1'b0}};
                end
            endcase
        end
    end

    assign cpu_rdata_o = cpu_rdata_s;
    assign mem_stall_o = stall_s;
    assign mem_req_o   = mem_req_r;
    assign mem_write_o = mem_write_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: cold miss, write hit, dirty conflict,
// streaming hits, read+write strobes and reset during a refill.
module tb_dcache_ctrl;

    logic         clk;
    logic         rst;
    logic [31:0]  cpu_addr_s;
    logic [31:0]  cpu_wdata_s;
    logic         cpu_read_s;
    logic         cpu_write_s;
    logic [31:0]  cpu_rdata_s;
    logic         stall_s;
    logic         mem_req_s;
    logic         mem_write_s;
    logic [31:0]  mem_addr_s;
    logic [255:0] mem_wdata_s;
    logic [255:0] mem_rdata_s;
    logic         mem_ack_s;

    int checks_r;
    int errors_r;

    logic [255:0] line_a_s;
    logic [255:0] line_b_s;
    logic [255:0] line_c_s;
    logic [255:0] exp_line_s;
    logic [31:0]  exp_word_s;

    dcache_ctrl #(.LINES(32), .TAG_W(22)) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_addr_i      (cpu_addr_s),
        .cpu_wdata_i     (cpu_wdata_s),
        .cpu_mem_read_i  (cpu_read_s),
        .cpu_mem_write_i (cpu_write_s),
        .cpu_rdata_o     (cpu_rdata_s),
        .mem_stall_o     (stall_s),
        .mem_req_o       (mem_req_s),
        .mem_write_o     (mem_write_s),
        .mem_addr_o      (mem_addr_s),
        .mem_wdata_o     (mem_wdata_s),
        .mem_rdata_i     (mem_rdata_s),
        .mem_ack_i       (mem_ack_s)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge, leaving time for outputs to settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = base + w;
        return l;
    endfunction

    initial begin
        checks_r    = 0;
        errors_r    = 0;
        line_a_s    = make_line(32'hA000_0000);
        line_b_s    = make_line(32'hB000_0000);
        line_c_s    = make_line(32'hC000_0000);
        rst         = 1'b1;
        cpu_addr_s  = 32'h0;
        cpu_wdata_s = 32'h0;
        cpu_read_s  = 1'b0;
        cpu_write_s = 1'b0;
        mem_rdata_s = 256'h0;
        mem_ack_s   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state, no request
        check_val("rst_stall", {255'h0, stall_s}, 256'h0);
        check_val("rst_req", {255'h0, mem_req_s}, 256'h0);
        check_val("rst_write", {255'h0, mem_write_s}, 256'h0);
        check_val("rst_addr", {224'h0, mem_addr_s}, 256'h0);
        check_val("rst_wdata", mem_wdata_s, 256'h0);
        check_val("rst_rdata", {224'h0, cpu_rdata_s}, 256'h0);

        // Cold read of 0x40, ack in the third refill cycle -> 4 stall cycles
        cpu_addr_s = 32'h0000_0040;
        cpu_read_s = 1'b1;
        #1;
        check_val("cold_stall_c0", {255'h0, stall_s}, 256'h1);
        check_val("cold_rdata_c0", {224'h0, cpu_rdata_s}, 256'h0);
        tick();
        check_val("cold_stall_c1", {255'h0, stall_s}, 256'h1);
        check_val("cold_req", {255'h0, mem_req_s}, 256'h1);
        check_val("cold_wr", {255'h0, mem_write_s}, 256'h0);
        check_val("cold_addr", {224'h0, mem_addr_s}, 256'h40);
        tick();
        check_val("cold_stall_c2", {255'h0, stall_s}, 256'h1);
        tick();
        mem_ack_s   = 1'b1;
        mem_rdata_s = line_a_s;
        #1;
        check_val("cold_stall_c3", {255'h0, stall_s}, 256'h1);
        tick();
        mem_ack_s = 1'b0;
        #1;
        check_val("cold_stall_c4", {255'h0, stall_s}, 256'h0);
        check_val("cold_rdata", {224'h0, cpu_rdata_s}, {224'h0, 32'hA000_0000});
        check_val("cold_req_done", {255'h0, mem_req_s}, 256'h0);

        // Write hit then read hit of 0x44
        cpu_read_s  = 1'b0;
        cpu_write_s = 1'b1;
        cpu_addr_s  = 32'h0000_0044;
        cpu_wdata_s = 32'hDEAD_BEEF;
        #1;
        check_val("wr_hit_stall", {255'h0, stall_s}, 256'h0);
        check_val("wr_hit_rdata", {224'h0, cpu_rdata_s}, 256'h0);
        tick();
        cpu_write_s = 1'b0;
        cpu_read_s  = 1'b1;
        #1;
        check_val("rd_hit_stall", {255'h0, stall_s}, 256'h0);
        check_val("rd_hit_data", {224'h0, cpu_rdata_s}, {224'h0, 32'hDEAD_BEEF});

        // Conflict read of 0x440 evicts the dirty 0x40 line
        cpu_addr_s = 32'h0000_0440;
        #1;
        check_val("conf_stall", {255'h0, stall_s}, 256'h1);
        tick();
        exp_line_s = line_a_s;
        exp_line_s[63:32] = 32'hDEAD_BEEF;
        check_val("wb_req", {255'h0, mem_req_s}, 256'h1);
        check_val("wb_write", {255'h0, mem_write_s}, 256'h1);
        check_val("wb_addr", {224'h0, mem_addr_s}, 256'h40);
        check_val("wb_wdata", mem_wdata_s, exp_line_s);
        tick();
        check_val("wb_addr_hold", {224'h0, mem_addr_s}, 256'h40);
        mem_ack_s = 1'b1;
        tick();
        mem_ack_s = 1'b0;
        #1;
        check_val("alloc_req", {255'h0, mem_req_s}, 256'h1);
        check_val("alloc_write", {255'h0, mem_write_s}, 256'h0);
        check_val("alloc_addr", {224'h0, mem_addr_s}, 256'h440);
        mem_ack_s   = 1'b1;
        mem_rdata_s = line_b_s;
        tick();
        mem_ack_s = 1'b0;
        #1;
        check_val("conf_done_stall", {255'h0, stall_s}, 256'h0);
        check_val("conf_rdata", {224'h0, cpu_rdata_s}, {224'h0, 32'hB000_0000});

        // Clean line: going back to 0x40 skips writeback
        cpu_addr_s = 32'h0000_0040;
        tick();
        check_val("clean_write", {255'h0, mem_write_s}, 256'h0);
        check_val("clean_addr", {224'h0, mem_addr_s}, 256'h40);
        mem_ack_s   = 1'b1;
        mem_rdata_s = exp_line_s;
        tick();
        mem_ack_s = 1'b0;

        // Eight back-to-back read hits across the resident line
        for (int w = 0; w < 8; w++) begin
            cpu_addr_s = 32'h0000_0040 + 32'(w * 4);
            exp_word_s = exp_line_s[w*32 +: 32];
            #1;
            check_val($sformatf("stream_stall_%0d", w), {255'h0, stall_s}, 256'h0);
            check_val($sformatf("stream_data_%0d", w), {224'h0, cpu_rdata_s}, {224'h0, exp_word_s});
            tick();
        end

        // Read and write strobes together on a hit act as a store
        cpu_addr_s  = 32'h0000_0048;
        cpu_wdata_s = 32'h1234_5678;
        cpu_read_s  = 1'b1;
        cpu_write_s = 1'b1;
        #1;
        check_val("rw_stall", {255'h0, stall_s}, 256'h0);
        check_val("rw_rdata", {224'h0, cpu_rdata_s}, 256'h0);
        tick();
        cpu_write_s = 1'b0;
        #1;
        check_val("rw_readback", {224'h0, cpu_rdata_s}, {224'h0, 32'h1234_5678});

        // Reset during ALLOCATE before ack
        cpu_addr_s = 32'h0000_1060;
        tick();
        check_val("rstmid_req", {255'h0, mem_req_s}, 256'h1);
        check_val("rstmid_addr", {224'h0, mem_addr_s}, 256'h1060);
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        mem_ack_s   = 1'b1;
        mem_rdata_s = line_b_s;
        #1;
        check_val("rstmid_req_drop", {255'h0, mem_req_s}, 256'h0);
        check_val("rstmid_stall", {255'h0, stall_s}, 256'h1);
        tick();
        mem_ack_s = 1'b0;
        #1;
        check_val("rstmid_remiss_req", {255'h0, mem_req_s}, 256'h1);
        check_val("rstmid_remiss_addr", {224'h0, mem_addr_s}, 256'h1060);
        check_val("rstmid_remiss_wr", {255'h0, mem_write_s}, 256'h0);
        mem_ack_s   = 1'b1;
        mem_rdata_s = line_c_s;
        tick();
        mem_ack_s = 1'b0;
        #1;
        check_val("rstmid_final_stall", {255'h0, stall_s}, 256'h0);
        check_val("rstmid_final_data", {224'h0, cpu_rdata_s}, {224'h0, 32'hC000_0000});

        cpu_read_s = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule
